// File: rtl/result_byte_streamer.sv
// Purpose  : reads the binarised result memory in raster order, packs 8 pixels per byte
//            (MSB = lowest column) and streams the bytes over valid/ready.
// Latency  : first byte valid 9 edges after start is sampled; 10 cycles per byte when unstalled.
// Backpres.: oByte/oValid hold while iReady=0; fetching pauses with the address frozen.
// Ports    : clock/reset (async, active-high); iStart; oResultCol/oResultRow + iResultData
//            (sync RAM, 1-cycle read latency); oByte/oValid/iReady stream; oBusy; finished.
module result_byte_streamer #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    input  logic                   iResultData,
    output logic [7:0]             oByte,
    output logic                   oValid,
    input  logic                   iReady,
    output logic                   oBusy,
    output logic                   finished
);
    localparam int WIDTH   = 2 ** WIDTH_BITS;
    localparam int HEIGHT  = 2 ** HEIGHT_BITS;
    localparam int PW      = WIDTH_BITS + HEIGHT_BITS + 1;
    localparam int NUM_PIX = WIDTH * HEIGHT;

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [3:0]    cnt;
    logic [6:0]    shreg;

    // pos only ever reaches NUM_PIX exactly, which is the point its MSB sets.
    logic all_fetched;
    assign all_fetched = (pos == PW'(NUM_PIX));

    // Address tracks pos directly, so it holds during SEND and wraps to 0 in DONE.
    assign {oResultRow, oResultCol} = pos[PW-2:0];
    assign oBusy = (state == READ) || (state == SEND);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            cnt      <= '0;
            shreg    <= '0;
            oByte    <= '0;
            oValid   <= 1'b0;
            finished <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state <= READ;
                        pos   <= '0;
                        cnt   <= '0;
                    end
                end
                READ: begin
                    // Addresses issue on cnt 0..7; data lags one cycle so it is
                    // captured on cnt 1..8.
                    if (cnt < 4'd8)
                        pos <= pos + 1'b1;
                    if (cnt != 4'd0)
                        shreg <= {shreg[5:0], iResultData};
                    if (cnt == 4'd8) begin
                        oByte  <= {shreg, iResultData};
                        oValid <= 1'b1;
                        state  <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        cnt    <= '0;
                        if (all_fetched) begin
                            state    <= DONE;
                            finished <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    if (iStart) begin
                        state    <= READ;
                        pos      <= '0;
                        cnt      <= '0;
                        finished <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_byte_streamer.sv
module tb_result_byte_streamer;
    logic       clock;
    logic       reset;
    logic       start;
    logic       ready;
    logic [2:0] col;
    logic [1:0] row;
    logic       rdata;
    logic [7:0] obyte;
    logic       ovalid;
    logic       busy;
    logic       fin;

    logic        reset2;
    logic        start2;
    logic        ready2;
    logic [7:0]  col2;
    logic [7:0]  row2;
    logic        rdata2;
    logic [7:0]  obyte2;
    logic        ovalid2;
    logic        busy2;
    logic        fin2;

    int n_checks;
    int n_fail;

    logic       mem [0:31];
    logic [7:0] rows [0:3];

    result_byte_streamer #(.WIDTH_BITS(3), .HEIGHT_BITS(2)) dut (
        .clock(clock), .reset(reset), .iStart(start),
        .oResultCol(col), .oResultRow(row), .iResultData(rdata),
        .oByte(obyte), .oValid(ovalid), .iReady(ready),
        .oBusy(busy), .finished(fin)
    );

    result_byte_streamer dut_big (
        .clock(clock), .reset(reset2), .iStart(start2),
        .oResultCol(col2), .oResultRow(row2), .iResultData(rdata2),
        .oByte(obyte2), .oValid(ovalid2), .iReady(ready2),
        .oBusy(busy2), .finished(fin2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM models, one cycle read latency.
    always @(posedge clock) begin
        rdata  <= mem[{row, col}];
        rdata2 <= ~(row2[0] ^ col2[0]);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for a valid byte, then accepts it with a one-cycle ready pulse.
    task automatic get_byte(output logic [7:0] b, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 40 && !ovalid; i++)
            tick();
        if (!ovalid) ok = 1'b0;
        b = obyte;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ovalid !== 1'b0 || fin !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b finished=%b busy=%b, required 0 0 0", ovalid, fin, busy);
        end
        n_checks++;
        if (obyte !== 8'h00 || {row, col} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: byte=%h addr=%h, required 00 00", obyte, {row, col});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timing();
        ready = 1'b1;
        start = 1'b1;
        tick();                 // E0 samples start
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++;
            if (ovalid !== ((k % 10) == 9)) begin
                n_fail++;
                $display("FAIL timing_valid E%0d: valid=%b, required %b", k, ovalid, ((k % 10) == 9));
            end
            if ((k % 10) == 9) begin
                n_checks++;
                if (obyte !== rows[k / 10]) begin
                    n_fail++;
                    $display("FAIL timing_byte%0d: byte=%h, required %h", k / 10, obyte, rows[k / 10]);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timing_busy: busy=%b, required 1", busy);
                end
            end
        end
        n_checks++;
        if (fin !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timing_done: finished=%b busy=%b, required 1 0", fin, busy);
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        get_byte(b, ok);
        n_checks++;
        if (!ok || b !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_byte0: byte=%h ok=%0d, required a5", b, ok);
        end
        for (int i = 0; i < 40 && !ovalid; i++)
            tick();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (ovalid !== 1'b1 || obyte !== 8'h3C || row !== 2'd2 || col !== 3'd0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b byte=%h row=%0d col=%0d, required 1 3c 2 0",
                         i, ovalid, obyte, row, col);
            end
            tick();
        end
        for (int j = 1; j < 4; j++) begin
            get_byte(b, ok);
            n_checks++;
            if (!ok || b !== rows[j]) begin
                n_fail++;
                $display("FAIL bp_byte%0d: byte=%h ok=%0d, required %h", j, b, ok, rows[j]);
            end
        end
        n_checks++;
        if (fin !== 1'b1 || ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: finished=%b valid=%b, required 1 0", fin, ovalid);
        end
    endtask

    task automatic test_restart();
        logic [7:0] b;
        bit ok;
        int first_edge;
        start = 1'b1;
        tick();                 // E0, from DONE
        start = 1'b0;
        n_checks++;
        if (fin !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: finished=%b busy=%b, required 0 1", fin, busy);
        end
        tick();
        tick();
        start = 1'b1;           // sampled at E3 while in READ
        tick();
        start = 1'b0;
        first_edge = -1;
        for (int k = 4; k < 30 && first_edge < 0; k++) begin
            tick();
            if (ovalid) first_edge = k;
        end
        n_checks++;
        if (first_edge !== 9) begin
            n_fail++;
            $display("FAIL restart_latency: first valid at E%0d, required E9", first_edge);
        end
        for (int j = 0; j < 4; j++) begin
            get_byte(b, ok);
            n_checks++;
            if (!ok || b !== rows[j]) begin
                n_fail++;
                $display("FAIL restart_byte%0d: byte=%h ok=%0d, required %h", j, b, ok, rows[j]);
            end
        end
        n_checks++;
        if (fin !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done: finished=%b, required 1", fin);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        get_byte(b, ok);
        get_byte(b, ok);
        for (int i = 0; i < 40 && !ovalid; i++)
            tick();
        n_checks++;
        if (ovalid !== 1'b1 || obyte !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_send: valid=%b byte=%h, required 1 ff", ovalid, obyte);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ovalid !== 1'b0 || fin !== 1'b0 || busy !== 1'b0 || {row, col} !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b finished=%b busy=%b addr=%h, required 0 0 0 00",
                     ovalid, fin, busy, {row, col});
        end
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        get_byte(b, ok);
        n_checks++;
        if (!ok || b !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_restart: byte=%h ok=%0d, required a5", b, ok);
        end
    endtask

    task automatic test_full_size();
        int nbytes;
        int nbad;
        int fin_edge;
        logic [7:0] exp;
        nbytes   = 0;
        nbad     = 0;
        fin_edge = -1;
        ready2   = 1'b1;
        start2   = 1'b1;
        tick();                 // E0
        start2 = 1'b0;
        for (int k = 1; k <= 82000 && fin_edge < 0; k++) begin
            tick();
            if (ovalid2) begin
                // 32 bytes per 256-pixel row; even rows start with a set pixel.
                exp = ((nbytes / 32) % 2 == 0) ? 8'hAA : 8'h55;
                if (obyte2 !== exp) nbad++;
                nbytes++;
            end
            if (fin2) fin_edge = k;
        end
        n_checks++;
        if (nbytes !== 8192) begin
            n_fail++;
            $display("FAIL big_count: bytes=%0d, required 8192", nbytes);
        end
        n_checks++;
        if (nbad !== 0) begin
            n_fail++;
            $display("FAIL big_pattern: wrong bytes=%0d, required 0", nbad);
        end
        n_checks++;
        if (fin_edge !== 81920) begin
            n_fail++;
            $display("FAIL big_finish: finished at E%0d, required E81920", fin_edge);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rows[0] = 8'hA5;
        rows[1] = 8'h3C;
        rows[2] = 8'hFF;
        rows[3] = 8'h00;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                mem[r * 8 + c] = rows[r][7 - c];
        reset  = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        reset2 = 1'b1;
        start2 = 1'b0;
        ready2 = 1'b0;

        test_reset();
        reset2 = 1'b0;
        test_timing();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_full_size();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
